// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP); optional MC_PERF_CNT_EN instret counter.
// Latency: ALU/jump 4 cycles, branch 3, load 5, store 4, plus memory wait states.
// Backpressure: mem_req held until mem_ready; MEM_TIMEOUT unanswered cycles traps with bus_err.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  state_t            cur_state, nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q, bus_err_q;
  logic              set_illegal, set_bus_err, retire, mem_expire;

  logic              legal;
  logic [2:0]        imm_dec;
  logic              alu_a_dec, alu_b_dec;
  logic [1:0]        alu_op_dec, wb_dec;

  always_comb begin
    legal      = 1'b1;
    imm_dec    = IMM_NONE;
    alu_a_dec  = 1'b0;
    alu_b_dec  = 1'b0;
    alu_op_dec = 2'd0;
    wb_dec     = 2'd0;
    case (opcode)
      OPC_LUI:    begin imm_dec = IMM_U; alu_b_dec = 1'b1; alu_op_dec = 2'd3; end
      OPC_AUIPC:  begin imm_dec = IMM_U; alu_a_dec = 1'b1; alu_b_dec = 1'b1; end
      OPC_JAL:    begin imm_dec = IMM_J; wb_dec = 2'd2; end
      OPC_JALR:   begin imm_dec = IMM_I; alu_b_dec = 1'b1; wb_dec = 2'd2; end
      OPC_BRANCH: begin imm_dec = IMM_B; alu_op_dec = 2'd1; end
      OPC_LOAD:   begin imm_dec = IMM_I; alu_b_dec = 1'b1; wb_dec = 2'd1; end
      OPC_STORE:  begin imm_dec = IMM_S; alu_b_dec = 1'b1; end
      OPC_OP_IMM: begin imm_dec = IMM_I; alu_b_dec = 1'b1; alu_op_dec = 2'd2; end
      OPC_OP:     begin alu_op_dec = 2'd2; end
      OPC_SYSTEM: begin imm_dec = IMM_I; wb_dec = 2'd3; end
      default:    legal = 1'b0;
    endcase
  end

  // A waiting access expires on its MEM_TIMEOUT-th unanswered cycle; mem_ready in that cycle still completes it.
  assign mem_expire = mem_req && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    imm_sel     = 3'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    alu_op      = 2'd0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    retire      = 1'b0;
    case (cur_state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end else if (mem_expire) begin
          set_bus_err = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_DECODE: begin
        imm_sel = imm_dec;
        if (legal) begin
          nxt_state = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_EXEC: begin
        imm_sel   = imm_dec;
        alu_src_a = alu_a_dec;
        alu_src_b = alu_b_dec;
        alu_op    = alu_op_dec;
        nxt_state = S_WB;
        case (opcode)
          OPC_LOAD, OPC_STORE: nxt_state = S_MEM;
          OPC_BRANCH: begin
            pc_write  = branch_taken;
            pc_sel    = 2'd1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end
          OPC_JAL: begin
            pc_write = 1'b1;
            pc_sel   = 2'd1;
          end
          OPC_JALR: begin
            pc_write = 1'b1;
            pc_sel   = 2'd2;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // ALU selects stay up so the computed address is stable for the whole access.
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (opcode == OPC_STORE);
        imm_sel   = imm_dec;
        alu_src_b = 1'b1;
        alu_op    = 2'd0;
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (mem_expire) begin
          set_bus_err = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_WB: begin
        imm_sel   = imm_dec;
        alu_src_a = alu_a_dec;
        alu_src_b = alu_b_dec;
        alu_op    = alu_op_dec;
        reg_write = 1'b1;
        wb_sel    = wb_dec;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_TRAP: nxt_state = S_TRAP;
      default: nxt_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = cur_state;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction flows, wait states, branch outcomes, timeout, illegal trap, reset.
module tb_multicycle_ctrl;

  logic        clk, rst_n;
  logic [6:0]  opcode;
  logic        mem_ready, branch_taken;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        illegal, bus_err;
  logic [2:0]  state;
  logic [31:0] instret;

  logic [31:0] ir;
  int checks  = 0;
  int errors  = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .state(state),
    .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
`ifdef MC_PERF_CNT_EN
    chk(tag, instret, exp_ret);
`else
    chk(tag, instret, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0; ir = 32'd0;
    #12;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_outs", {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, imm_sel,
                       alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, bus_err}, 32'd0);
    chk_ret("reset_instret");
    rst_n = 1'b1;

    tick(); chk("idle_to_fetch", {29'd0, state}, 32'd1);
    chk("fetch_bus", {mem_req, mem_we, addr_sel}, {29'd0, 3'b100});

    // addi, single-cycle memory
    ir = 32'h00A50293; opcode = ir[6:0]; mem_ready = 1'b1; #1;
    chk("fetch_done", {ir_write, pc_write, pc_sel}, {28'd0, 4'b1100});
    tick(); chk("addi_decode", {state, imm_sel}, {26'd0, 3'd2, 3'd0});
    tick(); chk("addi_exec", {state, alu_src_b, alu_op, reg_write}, {25'd0, 3'd3, 1'b1, 2'd2, 1'b0});
    tick(); chk("addi_wb", {state, reg_write, wb_sel}, {26'd0, 3'd5, 1'b1, 2'd0});
    tick(); chk("addi_back_fetch", {state, reg_write}, {28'd0, 3'd1, 1'b0}); exp_ret++;
    for (int i = 0; i < 2; i++) begin
      repeat (4) tick();
      chk("addi_4cyc", {29'd0, state}, 32'd1);
      exp_ret++;
    end
    chk_ret("instret_3addi");

    // sw with three wait states
    ir = 32'h0051A6A3; opcode = ir[6:0];
    tick(); chk("sw_decode", {state, imm_sel}, {26'd0, 3'd2, 3'd1});
    tick(); chk("sw_exec", {state, alu_src_b, alu_op, mem_req}, {25'd0, 3'd3, 1'b1, 2'd0, 1'b0});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_mem_wait", {state, mem_req, mem_we, addr_sel, reg_write, imm_sel},
          {22'd0, 3'd4, 4'b1110, 3'd1});
    end
    mem_ready = 1'b1; #1;
    chk("sw_mem_done", {state, mem_req, mem_we, addr_sel, reg_write}, {25'd0, 3'd4, 4'b1110});
    tick(); chk("sw_to_fetch", {29'd0, state}, 32'd1); exp_ret++;
    chk_ret("instret_sw");

    // beq taken then not taken
    ir = 32'h00208463; opcode = ir[6:0];
    tick(); chk("beq_decode", {state, imm_sel}, {26'd0, 3'd2, 3'd2});
    tick(); branch_taken = 1'b1; #1;
    chk("beq_taken", {state, pc_write, pc_sel, alu_op, imm_sel}, {21'd0, 3'd3, 1'b1, 2'd1, 2'd1, 3'd2});
    tick(); chk("beq_to_fetch", {29'd0, state}, 32'd1); exp_ret++;
    branch_taken = 1'b0;
    tick(); tick();
    chk("beq_not_taken", {state, pc_write, pc_sel}, {26'd0, 3'd3, 1'b0, 2'd1});
    tick(); chk("beq_nt_fetch", {29'd0, state}, 32'd1); exp_ret++;

    // jal / jalr
    opcode = 7'h6F;
    tick(); tick(); chk("jal_exec", {state, pc_write, pc_sel}, {26'd0, 3'd3, 1'b1, 2'd1});
    tick(); chk("jal_wb", {state, reg_write, wb_sel}, {26'd0, 3'd5, 1'b1, 2'd2});
    tick(); exp_ret++;
    opcode = 7'h67;
    tick(); tick(); chk("jalr_exec", {state, pc_write, pc_sel, imm_sel}, {23'd0, 3'd3, 1'b1, 2'd2, 3'd0});
    tick(); tick(); chk("jalr_fetch", {29'd0, state}, 32'd1); exp_ret++;
    chk_ret("instret_jumps");

    // lw, single-cycle memory
    opcode = 7'h03;
    tick(); tick(); tick();
    chk("lw_mem", {state, mem_req, mem_we, addr_sel}, {26'd0, 3'd4, 3'b101});
    tick(); chk("lw_wb", {state, reg_write, wb_sel}, {26'd0, 3'd5, 1'b1, 2'd1});
    tick(); exp_ret++;
    chk_ret("instret_lw");

    // fetch answered on the 16th waiting cycle: no error
    opcode = 7'h13; mem_ready = 1'b0;
    repeat (15) tick();
    chk("fetch_wait15", {state, mem_req, bus_err}, {27'd0, 3'd1, 1'b1, 1'b0});
    mem_ready = 1'b1; #1;
    chk("fetch_ready16", {31'd0, ir_write}, 32'd1);
    tick(); chk("no_bus_err", {state, bus_err}, {28'd0, 3'd2, 1'b0});
    tick(); tick(); tick(); exp_ret++;
    chk("addi_after_wait", {29'd0, state}, 32'd1);

    // fetch unanswered for 16 cycles: bus error trap
    mem_ready = 1'b0;
    repeat (15) tick();
    chk("timeout_edge", {state, bus_err}, {28'd0, 3'd1, 1'b0});
    tick();
    chk("timeout_trap", {state, bus_err, mem_req, illegal}, {26'd0, 3'd7, 1'b1, 1'b0, 1'b0});
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_hold", {state, mem_req, ir_write, pc_write, reg_write, bus_err},
          {24'd0, 3'd7, 4'b0000, 1'b1});
    end
    chk_ret("instret_at_trap");

    rst_n = 1'b0; #1;
    exp_ret = 0;
    chk("reset_clears_trap", {state, bus_err}, 32'd0);
    #1; rst_n = 1'b1;
    tick(); chk("refetch", {29'd0, state}, 32'd1);

    // reset asserted in the middle of a memory access
    opcode = 7'h03;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("lw_mem_pending", {state, mem_req}, {28'd0, 3'd4, 1'b1});
    #2; rst_n = 1'b0; #1;
    chk("async_drop", {state, mem_req, addr_sel, reg_write}, 32'd0);
    chk_ret("instret_reset");
    #1; rst_n = 1'b1; mem_ready = 1'b1;
    tick(); chk("refetch2", {29'd0, state}, 32'd1);

    // illegal opcode traps from DECODE
    opcode = 7'b0000000;
    tick(); chk("illegal_decode", {state, illegal}, {28'd0, 3'd2, 1'b0});
    tick(); chk("illegal_trap", {state, illegal, mem_req}, {27'd0, 3'd7, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("illegal_hold", {state, illegal, mem_req, bus_err}, {26'd0, 3'd7, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b0; #1;
    chk("reset_clears_illegal", {state, illegal}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
